move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5_000_000: cycles to wait for a location sample before a retry.
REQ-002 Parameter MAX_RETRIES, default 2: command resends allowed per phase before error.
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins an orient-and-move sequence.
REQ-006 abort  input  1  one-cycle pulse that cancels any sequence.
REQ-007 target_location  input  4  destination grid code, sampled on start.
REQ-008 location_valid  input  1  one-cycle pulse: new rover_location sample from the localizer.
REQ-009 rover_location  input  12  localizer location word, valid with location_valid.
REQ-010 calc_move_command  input  12  command word from the path calculator.
REQ-011 calc_orientation_done  input  1  calculator finished orientation.
REQ-012 tx_ready  input  1  IR transmitter can accept a command.
REQ-013 calc_enable  output  1  one-cycle enable pulse to the calculator.
REQ-014 calc_location  output  12  latched location presented to the calculator.
REQ-015 calc_target  output  4  latched target presented to the calculator.
REQ-016 tx_send  output  1  one-cycle pulse to the transmitter; tx_command valid.
REQ-017 tx_command  output  12  command word to the transmitter.
REQ-018 busy  output  1  high in every state except IDLE and ERROR.
REQ-019 done  output  1  one-cycle pulse when the sequence completes.
REQ-020 error  output  1  high while in ERROR.
REQ-021 state  output  4  current FSM state, exposed for debug.

Function
REQ-022 States SHALL be IDLE, WAIT_LOC0, SEND_CMD, WAIT_LOC1, WAIT_CALC, DONE and ERROR, with IDLE=0.
REQ-023 IDLE: on start, the block SHALL latch target_location into calc_target and go to WAIT_LOC0.
REQ-024 WAIT_LOC0: on location_valid, the block SHALL latch rover_location into calc_location, pulse calc_enable the next cycle, and go to SEND_CMD.
REQ-025 SEND_CMD: when calc_move_command!=0 and tx_ready=1, the block SHALL pulse tx_send with tx_command=calc_move_command, save that word as last_cmd, clear the timer, and go to WAIT_LOC1; with a zero command the block SHALL hold in SEND_CMD.
REQ-026 WAIT_LOC1: on location_valid, the block SHALL latch the location, pulse calc_enable, and go to WAIT_CALC.
REQ-027 WAIT_CALC: when calc_orientation_done=1, the block SHALL go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-028 location_valid in any state other than WAIT_LOC0 or WAIT_LOC1 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-029 abort SHALL force IDLE on the next edge from any state, win over a simultaneous start, and suppress any same-cycle tx_send, calc_enable or done.
REQ-030 ERROR SHALL be left only by start, which goes to WAIT_LOC0, or by abort, which goes to IDLE.
REQ-031 Start-to-first-calc_enable latency SHALL be 2 cycles after the location_valid cycle at the latest.

Reset
REQ-032 While reset=0, all outputs, the retry counter, the timer and last_cmd SHALL be 0, state SHALL be IDLE, and reset mid-sequence SHALL discard all latched data.

Configuration
REQ-033 With MOVE_SEQ_TIMEOUT_EN defined: in WAIT_LOC0 and WAIT_LOC1 a timer counts cycles.
  - At TIMEOUT_CYCLES with retries<MAX_RETRIES: retries increment, the timer clears, and tx_send is pulsed with last_cmd (WAIT_LOC1 only).
  - At TIMEOUT_CYCLES with retries==MAX_RETRIES: the block enters ERROR.
  - The retry counter clears on each accepted location.
  - When a timeout and location_valid occur in the same cycle, location_valid wins.
REQ-034 Without MOVE_SEQ_TIMEOUT_EN, no timer or retry logic SHALL be present, the wait states SHALL wait indefinitely, and error SHALL be tied to 0.

Structure
REQ-035 State encodings, the zero-command constant and the default parameter values SHALL live in the shared package rover_pkg.
REQ-036 The timer and retry counter SHALL be one sub-module, seq_timeout_timer, instantiated only under MOVE_SEQ_TIMEOUT_EN.

Verification
REQ-037 Nominal flow: start with target 4'h7; location 12'h123; calculator returns 12'h005 with tx_ready=1 -> calc_enable pulse with calc_location=12'h123, then tx_send with 12'h005; location 12'h130 -> second calc_enable; orientation_done -> done pulse, then IDLE.
REQ-038 Command gating: tx_ready=0 for 10 cycles in SEND_CMD -> no tx_send; tx_ready then rises -> exactly one tx_send.
REQ-039 Abort and start together in WAIT_LOC1 -> state IDLE the next cycle, no further outputs, busy=0.
REQ-040 Timeout, with TIMEOUT_CYCLES=16, MAX_RETRIES=2 and no location -> two resends of 12'h005 at 16-cycle intervals, then error=1; a following start -> WAIT_LOC0 with error=0.
REQ-041 Reset mid-sequence: reset low in WAIT_CALC -> outputs 0 and state IDLE immediately, without waiting for a clock edge.
REQ-042 Stray location_valid in IDLE, and start while busy -> no state change.

Source files
------------

// File: rtl/rover_pkg.sv
// rtl/rover_pkg.sv - shared state encodings, constants and defaults for the move sequencer
package rover_pkg;

    localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd5_000_000;
    localparam int unsigned MAX_RETRIES_DEFAULT    = 2;
    localparam logic [11:0] ZERO_CMD               = 12'h000;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_LOC0 = 4'd1,
        ST_SEND_CMD  = 4'd2,
        ST_WAIT_LOC1 = 4'd3,
        ST_WAIT_CALC = 4'd4,
        ST_DONE      = 4'd5,
        ST_ERROR     = 4'd6
    } seq_state_e;

endpackage

// File: rtl/seq_timeout_timer.sv
// rtl/seq_timeout_timer.sv - location-wait timer and retry counter for the move sequencer
module seq_timeout_timer
    import rover_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic run_i,
    input  logic retry_i,
    input  logic clr_retry_i,
    output logic expire_o,
    output logic exhausted_o
);

    localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);

    logic [23:0] timer_q, timer_d;
    logic [7:0]  retries_q, retries_d;

    assign expire_o    = run_i && (timer_q == TIMEOUT_CYCLES - 24'd1);
    assign exhausted_o = (retries_q >= MAX_R);

    // Timer only runs in a wait state and restarts after each expiry.
    always_comb begin
        timer_d   = timer_q + 24'd1;
        retries_d = retries_q;
        if (!run_i || expire_o) begin
            timer_d = 24'd0;
        end
        if (clr_retry_i) begin
            retries_d = 8'd0;
        end else if (retry_i) begin
            retries_d = retries_q + 8'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q   <= 24'd0;
            retries_q <= 8'd0;
        end else begin
            timer_q   <= timer_d;
            retries_q <= retries_d;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - orient-and-move sequencer; MOVE_SEQ_TIMEOUT_EN adds timeout/retry
module move_sequencer
    import rover_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  target_location,
    input  logic        location_valid,
    input  logic [11:0] rover_location,
    input  logic [11:0] calc_move_command,
    input  logic        calc_orientation_done,
    input  logic        tx_ready,
    output logic        calc_enable,
    output logic [11:0] calc_location,
    output logic [3:0]  calc_target,
    output logic        tx_send,
    output logic [11:0] tx_command,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  state
);

    seq_state_e  state_q, state_d;
    logic [3:0]  target_q, target_d;
    logic [11:0] loc_q, loc_d;
    logic [11:0] cmd_q, cmd_d;
    logic [11:0] last_cmd_q, last_cmd_d;
    logic        calc_en_q, calc_en_d;
    logic        tx_send_q, tx_send_d;
    logic        done_q, done_d;
    logic        retry, clr_retry;
    logic        expire, exhausted;
    logic        in_wait;

    assign in_wait = (state_q == ST_WAIT_LOC0) || (state_q == ST_WAIT_LOC1);

`ifdef MOVE_SEQ_TIMEOUT_EN
    seq_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .run_i      (in_wait),
        .retry_i    (retry),
        .clr_retry_i(clr_retry),
        .expire_o   (expire),
        .exhausted_o(exhausted)
    );
    assign error = (state_q == ST_ERROR);
`else
    logic unused_timer;
    assign expire       = 1'b0;
    assign exhausted    = 1'b0;
    assign error        = 1'b0;
    assign unused_timer = ^{retry, clr_retry, in_wait, TIMEOUT_CYCLES, 8'(MAX_RETRIES)};
`endif

    assign calc_enable   = calc_en_q;
    assign calc_location = loc_q;
    assign calc_target   = target_q;
    assign tx_send       = tx_send_q;
    assign tx_command    = cmd_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign state         = state_q;

    // Next-state and registered-pulse decode; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        loc_d      = loc_q;
        cmd_d      = cmd_q;
        last_cmd_d = last_cmd_q;
        calc_en_d  = 1'b0;
        tx_send_d  = 1'b0;
        done_d     = 1'b0;
        retry      = 1'b0;
        clr_retry  = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            clr_retry = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        target_d  = target_location;
                        clr_retry = 1'b1;
                        state_d   = ST_WAIT_LOC0;
                    end
                end
                ST_WAIT_LOC0, ST_WAIT_LOC1: begin
                    if (location_valid) begin
                        loc_d     = rover_location;
                        calc_en_d = 1'b1;
                        clr_retry = 1'b1;
                        state_d   = (state_q == ST_WAIT_LOC0) ? ST_SEND_CMD : ST_WAIT_CALC;
                    end else if (expire) begin
                        if (exhausted) begin
                            state_d = ST_ERROR;
                        end else begin
                            retry = 1'b1;
                            if (state_q == ST_WAIT_LOC1) begin
                                tx_send_d = 1'b1;
                                cmd_d     = last_cmd_q;
                            end
                        end
                    end
                end
                ST_SEND_CMD: begin
                    if ((calc_move_command != ZERO_CMD) && tx_ready) begin
                        tx_send_d  = 1'b1;
                        cmd_d      = calc_move_command;
                        last_cmd_d = calc_move_command;
                        state_d    = ST_WAIT_LOC1;
                    end
                end
                ST_WAIT_CALC: begin
                    if (calc_orientation_done) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched data and output pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            target_q   <= 4'd0;
            loc_q      <= 12'd0;
            cmd_q      <= 12'd0;
            last_cmd_q <= 12'd0;
            calc_en_q  <= 1'b0;
            tx_send_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            loc_q      <= loc_d;
            cmd_q      <= cmd_d;
            last_cmd_q <= last_cmd_d;
            calc_en_q  <= calc_en_d;
            tx_send_q  <= tx_send_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - directed self-checking bench for move_sequencer
module tb_move_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  target_location = 4'd0;
    logic        location_valid = 1'b0;
    logic [11:0] rover_location = 12'd0;
    logic [11:0] calc_move_command = 12'd0;
    logic        calc_orientation_done = 1'b0;
    logic        tx_ready = 1'b0;
    logic        calc_enable;
    logic [11:0] calc_location;
    logic [3:0]  calc_target;
    logic        tx_send;
    logic [11:0] tx_command;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    move_sequencer #(
        .TIMEOUT_CYCLES(24'd16),
        .MAX_RETRIES   (2)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .abort                (abort),
        .target_location      (target_location),
        .location_valid       (location_valid),
        .rover_location       (rover_location),
        .calc_move_command    (calc_move_command),
        .calc_orientation_done(calc_orientation_done),
        .tx_ready             (tx_ready),
        .calc_enable          (calc_enable),
        .calc_location        (calc_location),
        .calc_target          (calc_target),
        .tx_send              (tx_send),
        .tx_command           (tx_command),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .state                (state)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int tx_cnt;
    int first_tx;
    int second_tx;
    int err_at;

    initial begin
        // Reset state
        #3;
        check_eq("rst_state", state, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_outs", {calc_enable, tx_send, done, error, calc_location, calc_target, tx_command}, 0);
        step();
        reset = 1'b1;

        // Nominal flow
        calc_move_command = 12'h005;
        tx_ready = 1'b1;
        start = 1'b1; target_location = 4'h7;
        step();
        start = 1'b0;
        check_eq("nom_wait_loc0", state, 1);
        check_eq("nom_target", calc_target, 4'h7);
        check_eq("nom_busy", busy, 1);
        location_valid = 1'b1; rover_location = 12'h123;
        step();
        location_valid = 1'b0;
        check_eq("nom_send_state", state, 2);
        check_eq("nom_calc_en0", calc_enable, 1);
        check_eq("nom_calc_loc0", calc_location, 12'h123);
        step();
        check_eq("nom_tx_send", tx_send, 1);
        check_eq("nom_tx_cmd", tx_command, 12'h005);
        check_eq("nom_wait_loc1", state, 3);
        check_eq("nom_calc_en_low", calc_enable, 0);
        step();
        check_eq("nom_tx_send_end", tx_send, 0);
        location_valid = 1'b1; rover_location = 12'h130;
        step();
        location_valid = 1'b0;
        check_eq("nom_wait_calc", state, 4);
        check_eq("nom_calc_en1", calc_enable, 1);
        check_eq("nom_calc_loc1", calc_location, 12'h130);
        calc_orientation_done = 1'b1;
        step();
        calc_orientation_done = 1'b0;
        check_eq("nom_done", done, 1);
        check_eq("nom_done_state", state, 5);
        step();
        check_eq("nom_done_end", done, 0);
        check_eq("nom_idle", state, 0);
        check_eq("nom_idle_busy", busy, 0);

        // Command gating
        tx_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        location_valid = 1'b1; rover_location = 12'h200;
        step();
        location_valid = 1'b0;
        tx_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_send) tx_cnt++;
        end
        check_eq("gate_no_tx", tx_cnt, 0);
        check_eq("gate_hold", state, 2);
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_send) tx_cnt++;
        end
        check_eq("gate_one_tx", tx_cnt, 1);
        check_eq("gate_loc1", state, 3);

        // Abort with start and location in WAIT_LOC1
        abort = 1'b1; start = 1'b1; location_valid = 1'b1; rover_location = 12'h3ff;
        step();
        abort = 1'b0; start = 1'b0; location_valid = 1'b0;
        check_eq("abort_idle", state, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_no_pulse", {calc_enable, tx_send, done}, 0);
        tx_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (calc_enable || tx_send || done) tx_cnt++;
        end
        check_eq("abort_quiet", tx_cnt, 0);

        // Stray location in IDLE, start while busy
        location_valid = 1'b1; rover_location = 12'h0aa;
        step();
        location_valid = 1'b0;
        check_eq("stray_state", state, 0);
        check_eq("stray_calc_en", calc_enable, 0);
        start = 1'b1; target_location = 4'h7;
        step();
        target_location = 4'h3;
        step();
        start = 1'b0;
        check_eq("start_busy_state", state, 1);
        check_eq("start_busy_target", calc_target, 4'h7);

        // Reset mid-sequence in WAIT_CALC
        location_valid = 1'b1; rover_location = 12'h111;
        step();
        location_valid = 1'b0;
        step();
        location_valid = 1'b1; rover_location = 12'h222;
        step();
        location_valid = 1'b0;
        check_eq("mid_wait_calc", state, 4);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_state", state, 0);
        check_eq("mid_rst_outs", {busy, calc_enable, tx_send, done, error, calc_location, calc_target, tx_command}, 0);
        step();
        reset = 1'b1;

        // Timeout and retries (or indefinite wait without the feature)
        start = 1'b1; target_location = 4'h1;
        step();
        start = 1'b0;
        location_valid = 1'b1; rover_location = 12'h050;
        step();
        location_valid = 1'b0;
        step();
        check_eq("to_first_tx", tx_send, 1);
        first_tx = 0; second_tx = 0; err_at = 0; tx_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (tx_send) begin
                tx_cnt++;
                if (tx_cnt == 1) first_tx = i;
                if (tx_cnt == 2) second_tx = i;
                check_eq("to_resend_cmd", tx_command, 12'h005);
            end
            if (error && err_at == 0) err_at = i;
        end
`ifdef MOVE_SEQ_TIMEOUT_EN
        check_eq("to_resend_cnt", tx_cnt, 2);
        check_eq("to_resend1_at", first_tx, 16);
        check_eq("to_resend2_at", second_tx, 32);
        check_eq("to_error_at", err_at, 48);
        check_eq("to_error_state", state, 6);
        check_eq("to_error_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("to_restart_state", state, 1);
        check_eq("to_restart_error", error, 0);
`else
        check_eq("nt_resend_cnt", tx_cnt, 0);
        check_eq("nt_no_error", err_at, 0);
        check_eq("nt_still_wait", state, 3);
        check_eq("nt_busy", busy, 1);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("final_idle", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
